// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter between NREQ requesters,
// with per-packet ownership locking and a watchdog on every wait state.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 8000,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic [IDW-1:0]     owner,
  output logic               owner_vld,
  output logic               timeout_err,
  output logic [7:0]         err_cnt,
  output logic [1:0]         dbg_state
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] OWN_MAX = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t         r_state, w_next;
  logic [IDW-1:0] r_rr, r_owner, w_idx, w_inc;
  logic           r_lock, r_timeout_err;
  logic [WDW-1:0] r_wd;
  logic [7:0]     r_err_cnt;
  logic [DW-1:0]  r_tx_data;
  logic [DW-1:0]  w_data_arr [NREQ];
  logic           w_hit, w_wd_run, w_done, w_expire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) w_data_arr[i] = req_data[i*DW +: DW];
  end

  // While locked only the owner may continue; otherwise scan from the rr pointer.
  always_comb begin : p_scan
    int j;
    j     = 0;
    w_hit = 1'b0;
    w_idx = '0;
    if (r_lock) begin
      w_hit = req[r_owner];
      w_idx = r_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(r_rr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!w_hit && req[IDW'(j)]) begin
          w_hit = 1'b1;
          w_idx = IDW'(j);
        end
      end
    end
  end

  assign w_inc    = (r_owner == OWN_MAX) ? '0 : r_owner + IDW'(1);
  assign w_wd_run = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE) ||
                    ((r_state == S_IDLE) && r_lock && !req[r_owner]);
  assign w_done   = tx_done && ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE));
  // A completion landing on the expiry cycle wins over the watchdog.
  assign w_expire = w_wd_run && (r_wd == WD_LAST) && !w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    tx_start  = 1'b0;
    gnt       = '0;
    owner_vld = r_lock;
    case (r_state)
      S_IDLE: begin
        if (!w_expire && w_hit) w_next = S_START;
      end
      S_START: begin
        tx_start       = 1'b1;
        gnt[r_owner]   = 1'b1;
        owner_vld      = 1'b1;
        w_next         = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        owner_vld = 1'b1;
        if (tx_done || w_expire) w_next = S_IDLE;
        else if (tx_busy)        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        owner_vld = 1'b1;
        if (tx_done || w_expire) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr          <= '0;
      r_owner       <= '0;
      r_lock        <= 1'b0;
      r_wd          <= '0;
      r_err_cnt     <= '0;
      r_tx_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_expire;
      if ((w_next != r_state) || !w_wd_run || w_expire) r_wd <= '0;
      else                                             r_wd <= r_wd + WDW'(1);
      if ((r_state == S_IDLE) && !w_expire && w_hit) begin
        r_tx_data <= w_data_arr[w_idx];
        r_owner   <= w_idx;
        r_lock    <= ~req_last[w_idx];
      end
      if (w_expire) begin
        r_lock <= 1'b0;
        r_rr   <= w_inc;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (w_done && !r_lock) begin
        r_rr <= w_inc;
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign owner       = r_owner;
  assign timeout_err = r_timeout_err;
  assign err_cnt     = r_err_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: grant-order table, packet locking,
// watchdog expiry (stall and abandoned lock) and asynchronous reset mid-frame.
module tb_uart_tx_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int TO    = 8000;
  localparam int FRAME = 20;

  logic            clk, rst_n;
  logic [NREQ-1:0] req, req_last, gnt;
  logic [NREQ*DW-1:0] req_data;
  logic            tx_start, tx_busy, tx_done, owner_vld, timeout_err;
  logic [DW-1:0]   tx_data;
  logic [7:0]      err_cnt;
  logic [1:0]      owner, dbg_state;

  uart_tx_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .owner(owner), .owner_vld(owner_vld),
    .timeout_err(timeout_err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "time limit");
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_exp;
  int n_checks = 0;
  int n_errors = 0;
  logic model_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  task automatic default_data();
    for (int i = 0; i < NREQ; i++) set_data(i, 8'hA0 + 8'(i));
  endtask

  task automatic wait_gnt(input string name, input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == '0 && n < max);
    if (gnt == '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no grant within %0d cycles", name, max);
    end
  endtask

  task automatic wait_state(input string name, input logic [1:0] st, input int max);
    int n;
    n = 0;
    while (dbg_state != st && n < max) begin
      step();
      n++;
    end
    if (dbg_state != st) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: state %0d not reached, still %0d", name, st, dbg_state);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // transmitter model: busy one cycle after launch, done after FRAME cycles
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && rst_n && tx_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_byte: unexpected byte %0h", tx_data);
        end else begin
          model_exp = exp_q.pop_front();
          chk("tx_byte", tx_data, model_exp);
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
          tx_busy = 1'b1;
          for (int k = 0; k < FRAME && rst_n; k++) begin
            @(posedge clk);
            #1;
          end
          if (rst_n) begin
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(posedge clk);
            #1;
          end
        end
        tx_busy = 1'b0;
        tx_done = 1'b0;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t tbl[12];
  logic [NREQ-1:0] rr_exp[5];
  logic [DW-1:0]   pkt[3];
  int   n;
  logic flag;

  initial begin
    // vectors applied in order; rr pointer is 1 when the table starts
    tbl[0]  = '{4'b1111, 4'b0010, 8'hA1};
    tbl[1]  = '{4'b1111, 4'b0100, 8'hA2};
    tbl[2]  = '{4'b1111, 4'b1000, 8'hA3};
    tbl[3]  = '{4'b1111, 4'b0001, 8'hA0};
    tbl[4]  = '{4'b0001, 4'b0001, 8'hA0};
    tbl[5]  = '{4'b1001, 4'b1000, 8'hA3};
    tbl[6]  = '{4'b0110, 4'b0010, 8'hA1};
    tbl[7]  = '{4'b0011, 4'b0001, 8'hA0};
    tbl[8]  = '{4'b1000, 4'b1000, 8'hA3};
    tbl[9]  = '{4'b0100, 4'b0100, 8'hA2};
    tbl[10] = '{4'b0011, 4'b0001, 8'hA0};
    tbl[11] = '{4'b1010, 4'b0010, 8'hA1};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pkt     = '{8'h10, 8'h11, 8'h12};

    rst_n    = 1'b0;
    req      = '0;
    req_last = '1;
    req_data = '0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_owner_vld", owner_vld, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    step();

    // single byte
    set_data(0, 8'h41);
    req = 4'b0001;
    exp_q.push_back(8'h41);
    chk("single_no_early_gnt", gnt, 0);
    step();
    chk("single_gnt", gnt, 4'b0001);
    chk("single_tx_start", tx_start, 1);
    chk("single_tx_data", tx_data, 8'h41);
    chk("single_owner_vld", owner_vld, 1);
    req = '0;
    step();
    chk("single_start_one_cycle", tx_start, 0);
    chk("single_gnt_one_cycle", gnt, 0);
    wait_state("single_idle", 2'd0, 200);
    chk("single_owner_vld_idle", owner_vld, 0);
    chk("single_tx_data_hold", tx_data, 8'h41);

    // grant-order table
    default_data();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      exp_q.push_back(tbl[i].exp_data);
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_tx_start", i), tx_start, 1);
      chk($sformatf("tbl%0d_tx_data", i), tx_data, tbl[i].exp_data);
      req = '0;
      wait_state($sformatf("tbl%0d_idle", i), 2'd0, 200);
    end

    // round robin with all requests held
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) exp_q.push_back(8'hA0 + 8'($clog2(rr_exp[g])));
    for (int g = 0; g < 5; g++) begin
      wait_gnt($sformatf("rr%0d_wait", g), 200);
      chk($sformatf("rr%0d_gnt", g), gnt, rr_exp[g]);
    end
    req = '0;
    wait_state("rr_idle", 2'd0, 200);

    // packet lock: req0 sends 3 bytes while req1 keeps asking
    do_reset();
    set_data(1, 8'hB1);
    flag = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_data(0, pkt[b]);
      req_last = (b == 2) ? 4'b1111 : 4'b1110;
      req      = 4'b0011;
      exp_q.push_back(pkt[b]);
      n = 0;
      do begin
        step();
        n++;
        if (b > 0 && gnt == '0 && !owner_vld) flag = 1'b1;
      end while (gnt == '0 && n < 200);
      chk($sformatf("pkt%0d_gnt", b), gnt, 4'b0001);
      chk($sformatf("pkt%0d_owner", b), owner, 0);
    end
    req = 4'b0010;
    exp_q.push_back(8'hB1);
    wait_gnt("pkt_req1_wait", 200);
    chk("pkt_req1_gnt", gnt, 4'b0010);
    chk("pkt_owner_vld_held", flag, 0);
    req = '0;
    wait_state("pkt_idle", 2'd0, 200);

    // stalled transmitter (rr=2): req0 granted, no busy, watchdog fires
    default_data();
    req_last = '1;
    model_en = 1'b0;
    req = 4'b0011;
    step();
    chk("stall_gnt", gnt, 4'b0001);
    req = 4'b0010;
    step();
    chk("stall_wait_busy", dbg_state, 2);
    n = 0;
    while (!timeout_err && n < TO + 20) begin
      step();
      n++;
    end
    chk("stall_latency", n, TO);
    chk("stall_err_cnt", err_cnt, 1);
    chk("stall_state_idle", dbg_state, 0);
    model_en = 1'b1;
    exp_q.push_back(8'hA1);
    step();
    chk("stall_next_gnt", gnt, 4'b0010);
    chk("stall_err_pulse_width", timeout_err, 0);
    req = '0;
    wait_state("stall_idle", 2'd0, 200);

    // abandoned lock (rr=2): req2 sends last=0 then drops, req3 waits
    req_last = 4'b1011;
    req = 4'b1100;
    exp_q.push_back(8'hA2);
    step();
    chk("aband_gnt", gnt, 4'b0100);
    req = 4'b1000;
    wait_state("aband_idle", 2'd0, 200);
    chk("aband_locked_vld", owner_vld, 1);
    chk("aband_owner", owner, 2);
    flag = 1'b0;
    n = 0;
    while (!timeout_err && n < TO + 20) begin
      step();
      n++;
      if (gnt != '0) flag = 1'b1;
    end
    chk("aband_latency", n, TO);
    chk("aband_starved", flag, 0);
    chk("aband_err_cnt", err_cnt, 2);
    chk("aband_lock_clear", owner_vld, 0);
    req_last = '1;
    exp_q.push_back(8'hA3);
    step();
    chk("aband_req3_gnt", gnt, 4'b1000);
    req = '0;
    wait_state("aband_req3_idle", 2'd0, 200);

    // reset mid-frame: first move rr to 3 by serving requester 2
    req = 4'b0100;
    exp_q.push_back(8'hA2);
    step();
    chk("mid_pre_gnt", gnt, 4'b0100);
    req = '0;
    wait_state("mid_pre_idle", 2'd0, 200);
    req = 4'b0100;
    exp_q.push_back(8'hA2);
    step();
    chk("mid_gnt", gnt, 4'b0100);
    req = '0;
    wait_state("mid_wait_done", 2'd3, 200);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_owner_vld", owner_vld, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_state", dbg_state, 0);
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    req = 4'b1100;
    exp_q.push_back(8'hA2);
    step();
    chk("post_rst_gnt", gnt, 4'b0100);
    req = '0;
    wait_state("post_rst_idle", 2'd0, 200);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
